// File: rtl/sodor_scratchpad_responder.sv
// sodor_scratchpad_responder: single-port scratchpad behind the Sodor scratch port,
// with byte/half/word stores, extended loads and a fixed-latency response pipeline.
module sodor_scratchpad_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter logic [31:0] SIZE_BYTES   = 32'h0004_0000,
    parameter int          RESP_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_valid,
    input  logic [31:0] io_req_bits_addr,
    input  logic [31:0] io_req_bits_data,
    input  logic        io_req_bits_fcn,
    input  logic [2:0]  io_req_bits_typ,
    output logic        io_resp_valid,
    output logic [31:0] io_resp_bits_data,
    output logic [31:0] io_resp_addr,
    output logic [1:0]  io_resp_err
);
    localparam int AW    = $clog2(SIZE_BYTES);
    localparam int DEPTH = SIZE_BYTES / 4;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata, wdata, sh, ld;
    logic [AW-3:0] idx;
    logic [1:0]  lane, err;
    logic [3:0]  be;
    logic        is_b, is_h, is_w, in_range, we, re;

    logic        s1_valid, s1_zero;
    logic [31:0] s1_addr;
    logic [1:0]  s1_err, s1_lane;
    logic [2:0]  s1_typ;

    always_comb begin
        lane     = io_req_bits_addr[1:0];
        idx      = io_req_bits_addr[AW-1:2];
        is_b     = io_req_bits_typ == 3'd1 || io_req_bits_typ == 3'd5;
        is_h     = io_req_bits_typ == 3'd2 || io_req_bits_typ == 3'd6;
        is_w     = io_req_bits_typ == 3'd3;
        in_range = ((io_req_bits_addr ^ BASE_ADDR) & ~(SIZE_BYTES - 32'd1)) == 32'd0;
        err      = {~(is_b | is_h | is_w) | (is_h & lane[0]) | (is_w & |lane), ~in_range};
        be       = is_w ? 4'hf : is_h ? (4'b0011 << lane) : is_b ? (4'b0001 << lane) : 4'h0;
        wdata    = is_w ? io_req_bits_data : is_h ? {2{io_req_bits_data[15:0]}} : {4{io_req_bits_data[7:0]}};
        we       = io_req_valid & io_req_bits_fcn & (err == 2'b00);
        re       = io_req_valid & ~io_req_bits_fcn & (err == 2'b00);
    end

    always_ff @(posedge clock) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[idx];
    end

    // Metadata only advances on a request so outputs hold while valid is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b1;
            s1_addr  <= '0;
            s1_err   <= '0;
            s1_lane  <= '0;
            s1_typ   <= '0;
        end else begin
            s1_valid <= io_req_valid;
            if (io_req_valid) begin
                s1_zero <= io_req_bits_fcn | (err != 2'b00);
                s1_addr <= io_req_bits_addr;
                s1_err  <= err;
                s1_lane <= lane;
                s1_typ  <= io_req_bits_typ;
            end
        end
    end

    always_comb begin
        sh = rdata >> {s1_lane, 3'b000};
        ld = s1_zero             ? 32'd0 :
             s1_typ == 3'd1      ? {{24{sh[7]}}, sh[7:0]} :
             s1_typ == 3'd2      ? {{16{sh[15]}}, sh[15:0]} :
             s1_typ == 3'd5      ? {24'd0, sh[7:0]} :
             s1_typ == 3'd6      ? {16'd0, sh[15:0]} : sh;
    end

    generate
        if (RESP_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    io_resp_valid     <= 1'b0;
                    io_resp_bits_data <= '0;
                    io_resp_addr      <= '0;
                    io_resp_err       <= '0;
                end else begin
                    io_resp_valid <= s1_valid;
                    if (s1_valid) begin
                        io_resp_bits_data <= ld;
                        io_resp_addr      <= s1_addr;
                        io_resp_err       <= s1_err;
                    end
                end
            end
        end else begin : g_lat1
            assign io_resp_valid     = s1_valid;
            assign io_resp_bits_data = ld;
            assign io_resp_addr      = s1_addr;
            assign io_resp_err       = s1_err;
        end
    endgenerate
endmodule

// File: tb/tb_sodor_scratchpad_responder.sv
// tb_sodor_scratchpad_responder: directed requests with a response scoreboard.
module tb_sodor_scratchpad_responder;
    localparam int LAT = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_req_valid = 1'b0;
    logic [31:0] io_req_bits_addr = '0;
    logic [31:0] io_req_bits_data = '0;
    logic        io_req_bits_fcn = 1'b0;
    logic [2:0]  io_req_bits_typ = '0;
    logic        io_resp_valid;
    logic [31:0] io_resp_bits_data;
    logic [31:0] io_resp_addr;
    logic [1:0]  io_resp_err;

    sodor_scratchpad_responder #(.RESP_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_bits_addr(io_req_bits_addr),
        .io_req_bits_data(io_req_bits_data), .io_req_bits_fcn(io_req_bits_fcn),
        .io_req_bits_typ(io_req_bits_typ), .io_resp_valid(io_resp_valid),
        .io_resp_bits_data(io_resp_bits_data), .io_resp_addr(io_resp_addr),
        .io_resp_err(io_resp_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic [1:0]  err;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (reset && io_resp_valid) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_resp got data=%h addr=%h err=%b at cyc %0d, none expected",
                         io_resp_bits_data, io_resp_addr, io_resp_err, cyc);
            end else begin
                mon_e = q.pop_front();
                if (io_resp_bits_data !== mon_e.data || io_resp_addr !== mon_e.addr ||
                    io_resp_err !== mon_e.err || cyc != mon_e.due) begin
                    miscompares++;
                    $display("FAIL resp got data=%h addr=%h err=%b cyc=%0d want data=%h addr=%h err=%b cyc=%0d",
                             io_resp_bits_data, io_resp_addr, io_resp_err, cyc,
                             mon_e.data, mon_e.addr, mon_e.err, mon_e.due);
                end
            end
        end else if (q.size() > 0 && q[0].due < cyc) begin
            vectors++;
            miscompares++;
            mon_e = q.pop_front();
            $display("FAIL missing_resp addr=%h got no valid, want valid at cyc %0d", mon_e.addr, mon_e.due);
        end
    end

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic f,
                       input logic [2:0] t, input logic [31:0] ed, input logic [1:0] ee);
        @(posedge clock);
        #1;
        io_req_valid     = 1'b1;
        io_req_bits_addr = a;
        io_req_bits_data = d;
        io_req_bits_fcn  = f;
        io_req_bits_typ  = t;
        q.push_back('{ed, a, ee, cyc + LAT});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            io_req_valid = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("reset_valid", {31'd0, io_resp_valid}, 32'd0);
        check("reset_err", {30'd0, io_resp_err}, 32'd0);
        check("reset_data", io_resp_bits_data, 32'd0);
        check("reset_addr", io_resp_addr, 32'd0);

        req(32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 3'd3, 32'h0, 2'b00);
        req(32'h8000_0010, 32'h0,         1'b0, 3'd3, 32'hDEAD_BEEF, 2'b00);
        req(32'h8000_0013, 32'h0,         1'b0, 3'd1, 32'hFFFF_FFDE, 2'b00);
        req(32'h8000_0013, 32'h0,         1'b0, 3'd5, 32'h0000_00DE, 2'b00);
        req(32'h8000_0012, 32'h0,         1'b0, 3'd6, 32'h0000_DEAD, 2'b00);
        req(32'h8000_0010, 32'h0,         1'b0, 3'd2, 32'hFFFF_BEEF, 2'b00);
        idle(2);
        req(32'h8000_0011, 32'h0000_0055, 1'b1, 3'd1, 32'h0, 2'b00);
        req(32'h8000_0010, 32'h0,         1'b0, 3'd3, 32'hDEAD_55EF, 2'b00);
        req(32'h8000_0011, 32'h0,         1'b0, 3'd1, 32'h0000_0055, 2'b00);
        req(32'h8000_0011, 32'h0000_FFFF, 1'b1, 3'd2, 32'h0, 2'b10);
        req(32'h8000_0010, 32'h0,         1'b0, 3'd3, 32'hDEAD_55EF, 2'b00);

        req(32'h8000_0000, 32'h1234_5678, 1'b1, 3'd3, 32'h0, 2'b00);
        req(32'h8004_0000, 32'hCAFE_F00D, 1'b1, 3'd3, 32'h0, 2'b01);
        req(32'h8000_0000, 32'h0,         1'b0, 3'd3, 32'h1234_5678, 2'b00);
        req(32'h8004_0001, 32'h0,         1'b0, 3'd3, 32'h0, 2'b11);
        req(32'h8000_0000, 32'h0,         1'b0, 3'd4, 32'h0, 2'b10);

        req(32'h8000_0020, 32'h0,         1'b1, 3'd3, 32'h0, 2'b00);
        req(32'h8000_0022, 32'hFFFF_8001, 1'b1, 3'd2, 32'h0, 2'b00);
        req(32'h8000_0020, 32'h0,         1'b0, 3'd3, 32'h8001_0000, 2'b00);
        req(32'h8000_0022, 32'h0,         1'b0, 3'd6, 32'h0000_8001, 2'b00);
        req(32'h8000_0022, 32'h0,         1'b0, 3'd2, 32'hFFFF_8001, 2'b00);
        req(32'h8000_0021, 32'h0,         1'b0, 3'd6, 32'h0, 2'b10);

        req(32'h8000_0002, 32'h0,         1'b0, 3'd3, 32'h0, 2'b10);
        req(32'h8000_0000, 32'h0,         1'b0, 3'd7, 32'h0, 2'b10);
        idle(LAT + 2);

        req(32'h8000_0002, 32'h0, 1'b0, 3'd3, 32'h0, 2'b10);
        @(posedge clock);
        #1;
        reset = 1'b0;
        io_req_valid = 1'b0;
        q.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("post_reset_valid", {31'd0, io_resp_valid}, 32'd0);
        req(32'h8000_0000, 32'h0, 1'b0, 3'd7, 32'h0, 2'b10);
        idle(LAT + 3);
        check("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
